apb_initiator: RTL
==================

# apb_initiator

Requester side of the APB bus that the peripheral slaves (UART16550 wrapper, etc.) sit on. The block takes one-at-a-time register requests from a simple valid/ready command port and runs the APB SETUP/ACCESS sequence. It waits on `out_pready` and returns read data and error status on a valid/ready response port. A programmable ACCESS-phase timeout stops a hung peripheral from stalling the core.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum ACCESS-phase cycles before abort. 0 disables the timeout.
- `clock`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  1  command present.
- `req_ready`  out  1  block can accept a command.
- `req_addr`  in  32  byte address.
- `req_write`  in  1  1 = write, 0 = read.
- `req_wdata`  in  32  write data.
- `req_wstrb`  in  4  byte-lane strobes. Used on reads too, for lane selection.
- `req_prot`  in  3  APB protection attributes.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  consumer accepts response.
- `resp_rdata`  out  32  read data. 0 for writes and for timeouts.
- `resp_err`  out  1  `out_pslverr` sampled, or timeout.
- `resp_timeout`  out  1  transfer aborted by timeout.
- `out_psel`, `out_penable`, `out_pwrite`  out  1 each  APB controls.
- `out_paddr`  out  32  APB address.
- `out_pwdata`  out  32  APB write data.
- `out_pstrb`  out  4  APB strobes.
- `out_pprot`  out  3  APB protection attributes.
- `out_pready`, `out_pslverr`  in  1 each  APB completion and error.
- `out_prdata`  in  32  APB read data.

## Operation
- Four states: IDLE, SETUP, ACCESS, RESP.
- IDLE
  - `req_ready`=1 and no other state asserts it.
  - When `req_valid`&`req_ready`, latch addr/write/wdata/wstrb/prot into holding registers and go to SETUP.
- SETUP
  - `out_psel`=1, `out_penable`=0.
  - Unconditional move to ACCESS.
- ACCESS
  - `out_psel`=1, `out_penable`=1.
  - `out_pready`=1: capture `out_prdata` (reads only, else 0) and `out_pslverr` into `resp_rdata`/`resp_err`, clear `resp_timeout`, go to RESP.
  - `out_pready`=0: increment the wait counter. When the counter equals `TIMEOUT_CYCLES-1` and `TIMEOUT_CYCLES`≠0, go to RESP with `resp_err`=1, `resp_timeout`=1, `resp_rdata`=0.
- RESP
  - `out_psel`=`out_penable`=0, `resp_valid`=1.
  - When `resp_ready`, go to IDLE.
  - `resp_*` stay stable while `resp_valid`=1 and `resp_ready`=0.
- APB address/control outputs come straight from the holding registers. They are stable from SETUP through the last ACCESS cycle.
- `out_pstrb` = latched `req_wstrb` on both reads and writes. Byte-lane-decoding slaves need it on reads.
- Wait counter: 8 bits when `TIMEOUT_CYCLES`≤255, otherwise `$clog2(TIMEOUT_CYCLES+1)` bits. It clears on entry to SETUP and does not wrap.
- `out_pslverr` and `out_prdata` are ignored whenever `out_pready`=0.

## Timing
- Reset values:
  - state = IDLE, `req_ready`=1, `resp_valid`=0.
  - `out_psel`=`out_penable`=0.
  - All data/address/strb/prot outputs and `resp_*` = 0.
- Reset mid-transfer: the next edge forces IDLE, drops `out_psel`/`out_penable`, and discards any pending response. No response is produced for the aborted command.
- Zero-wait transfer: accept at edge N, SETUP in cycle N+1, ACCESS in cycle N+2 (`out_pready`=1), `resp_valid` in cycle N+3. Minimum of 3 cycles from accept to response.
- Each wait state adds one cycle.
- Timeout: with `TIMEOUT_CYCLES`=T and `out_pready` held low, ACCESS lasts exactly T cycles, then RESP.
- If `out_pready` rises in the same cycle the counter hits its limit, `out_pready` wins: normal completion, `resp_timeout`=0.
- Throughput:
  - No overlapping transfers. The next command is accepted only in IDLE, so the minimum period is 4 cycles with `resp_ready` held 1.
  - `req_ready` is 0 in the cycle `resp_valid`&`resp_ready` fires. It rises the following cycle.

## Test plan
- Zero-wait write: addr=0x10000000, wdata=0xA5A5A5A5, wstrb=4'b0001, `out_pready`=1 tied.
  - SETUP and ACCESS one cycle each with those values.
  - `resp_valid` in cycle N+3, `resp_err`=0, `resp_rdata`=0.
- Read with 3 wait states: addr=0x10000005, wstrb=4'b0010, slave returns 0x00003C00 in the 4th ACCESS cycle.
  - `resp_rdata`=0x00003C00, `resp_err`=0.
  - `resp_valid` in cycle N+6.
  - APB outputs stable across all ACCESS cycles.
- Slave error: `out_pslverr`=1 with `out_pready`.
  - `resp_err`=1, `resp_timeout`=0.
  - `out_pslverr` pulses while `out_pready`=0 are ignored.
- Timeout: `TIMEOUT_CYCLES`=8, `out_pready` held 0.
  - Exactly 8 ACCESS cycles.
  - `resp_err`=1, `resp_timeout`=1, `resp_rdata`=0.
  - Repeat with `out_pready` rising on the 8th cycle: normal completion, `resp_timeout`=0.
- Reset in the 2nd ACCESS cycle: `out_psel`=0 and `req_ready`=1 the next cycle, with no `resp_valid` ever.
- Backpressure: hold `resp_ready`=0 for 5 cycles after `resp_valid`.
  - `resp_*` stable, `req_ready`=0, and a new `req_valid` is not accepted until after the response handshake.

Source files
------------

// File: rtl/apb_initiator.sv
// apb_initiator: requester side of the peripheral APB bus.
// Accepts one register request at a time on a valid/ready command port, runs the
// APB SETUP/ACCESS handshake, and returns read data plus error/timeout status on a
// valid/ready response port. A bounded ACCESS-phase wait keeps a hung slave from
// stalling the core.
module apb_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_write,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    input  logic [2:0]  req_prot,

    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        resp_timeout,

    output logic        out_psel,
    output logic        out_penable,
    output logic        out_pwrite,
    output logic [31:0] out_paddr,
    output logic [31:0] out_pwdata,
    output logic [3:0]  out_pstrb,
    output logic [2:0]  out_pprot,
    input  logic        out_pready,
    input  logic        out_pslverr,
    input  logic [31:0] out_prdata
);

    // Wait counter is wide enough to reach TIMEOUT_CYCLES-1, never narrower than 8 bits.
    localparam int          CNT_W      = (TIMEOUT_CYCLES <= 255) ? 8 : $clog2(TIMEOUT_CYCLES + 1);
    localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam int unsigned LIMIT_INT  = TIMEOUT_EN ? (TIMEOUT_CYCLES - 1) : 0;
    localparam logic [CNT_W-1:0] LIMIT    = LIMIT_INT[CNT_W-1:0];
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;

    // Single transfer sequencer: state, registered handshake/APB controls, holding
    // registers that drive the APB address/data lines, and the captured response.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_IDLE;
            req_ready    <= 1'b1;
            resp_valid   <= 1'b0;
            resp_rdata   <= 32'd0;
            resp_err     <= 1'b0;
            resp_timeout <= 1'b0;
            out_psel     <= 1'b0;
            out_penable  <= 1'b0;
            out_pwrite   <= 1'b0;
            out_paddr    <= 32'd0;
            out_pwdata   <= 32'd0;
            out_pstrb    <= 4'd0;
            out_pprot    <= 3'd0;
            wait_cnt     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        out_paddr   <= req_addr;
                        out_pwrite  <= req_write;
                        out_pwdata  <= req_wdata;
                        out_pstrb   <= req_wstrb;
                        out_pprot   <= req_prot;
                        wait_cnt    <= '0;
                        req_ready   <= 1'b0;
                        out_psel    <= 1'b1;
                        out_penable <= 1'b0;
                        state       <= ST_SETUP;
                    end
                end

                ST_SETUP: begin
                    out_penable <= 1'b1;
                    state       <= ST_ACCESS;
                end

                ST_ACCESS: begin
                    if (out_pready) begin
                        resp_rdata   <= out_pwrite ? 32'd0 : out_prdata;
                        resp_err     <= out_pslverr;
                        resp_timeout <= 1'b0;
                        resp_valid   <= 1'b1;
                        out_psel     <= 1'b0;
                        out_penable  <= 1'b0;
                        state        <= ST_RESP;
                    end else if (TIMEOUT_EN && (wait_cnt == LIMIT)) begin
                        resp_rdata   <= 32'd0;
                        resp_err     <= 1'b1;
                        resp_timeout <= 1'b1;
                        resp_valid   <= 1'b1;
                        out_psel     <= 1'b0;
                        out_penable  <= 1'b0;
                        state        <= ST_RESP;
                    end else if (wait_cnt != CNT_MAX) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end

                default: begin
                    req_ready   <= 1'b1;
                    resp_valid  <= 1'b0;
                    out_psel    <= 1'b0;
                    out_penable <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
